// File: rtl/send_control_mc.sv
// send_control_mc: steps the TX frame builder through (segment, copy) pairs.
// Each frame is START -> wait for busy to rise (with timeout) -> wait for
// busy to fall -> programmable gap. Ordering is interleaved (copies inner)
// or block (segments inner).
module send_control_mc #(
  parameter int unsigned SEG_W       = 16,
  parameter int unsigned NUM_TX      = 3,
  parameter int unsigned AUX_W       = 8,
  parameter int unsigned SW_W        = 8,
  parameter int unsigned SEG_SHIFT   = 4,
  parameter int unsigned GAP_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             clk125MHz,
  input  logic             RST,
  input  logic             enable,
  input  logic             mode,
  input  logic [SW_W-1:0]  switches,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             busy,
  output logic [SEG_W-1:0] segment_num,
  output logic [7:0]       txid_inter,
  output logic [AUX_W-1:0] aux,
  output logic             start_sending,
  output logic [7:0]       timeout_cnt
);

  localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       TXID_LAST = 8'(NUM_TX - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]       state, state_d;
  logic [SEG_W-1:0] seg_max, seg_max_d;
  logic [ACK_W-1:0] ack_cnt, ack_cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [SEG_W-1:0] segment_num_d;
  logic [7:0]       txid_inter_d;
  logic [AUX_W-1:0] aux_d;
  logic             start_sending_d;
  logic [7:0]       timeout_cnt_d;

  logic [SEG_W-1:0] seg_max_sw;
  logic [SEG_W-1:0] adv_seg;
  logic [7:0]       adv_txid;
  logic [AUX_W-1:0] adv_aux;
  logic             adv_wrap;
  logic             advance;

  // Segment limit selected by the switches; truncation to SEG_W is intended.
  assign seg_max_sw = SEG_W'(((32'(switches) + 32'd1) << SEG_SHIFT) - 32'd1);

  // Indices the controller moves to when the current frame completes.
  always_comb begin
    adv_seg  = segment_num;
    adv_txid = txid_inter;
    adv_aux  = aux;
    adv_wrap = 1'b0;
    if (!mode) begin
      if (txid_inter == TXID_LAST) begin
        adv_txid = 8'd0;
        if (segment_num == seg_max) begin
          adv_seg  = '0;
          adv_wrap = 1'b1;
        end else begin
          adv_seg = segment_num + SEG_W'(1);
        end
      end else begin
        adv_txid = txid_inter + 8'd1;
      end
    end else begin
      if (segment_num == seg_max) begin
        adv_seg = '0;
        if (txid_inter == TXID_LAST) begin
          adv_txid = 8'd0;
          adv_wrap = 1'b1;
        end else begin
          adv_txid = txid_inter + 8'd1;
        end
      end else begin
        adv_seg = segment_num + SEG_W'(1);
      end
    end
    if (adv_wrap) adv_aux = aux + AUX_W'(1);
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d         = state;
    seg_max_d       = seg_max;
    ack_cnt_d       = ack_cnt;
    gap_cnt_d       = gap_cnt;
    segment_num_d   = segment_num;
    txid_inter_d    = txid_inter;
    aux_d           = aux;
    start_sending_d = 1'b0;
    timeout_cnt_d   = timeout_cnt;
    advance         = 1'b0;

    case (state)
      S_IDLE: begin
        seg_max_d = seg_max_sw;
        if (enable) begin
          state_d         = S_START;
          start_sending_d = 1'b1;
        end
      end
      S_START: begin
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          if (timeout_cnt != 8'hFF) timeout_cnt_d = timeout_cnt + 8'd1;
          advance = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt + ACK_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy) advance = 1'b1;
      end
      S_GAP: begin
        if (gap_cnt == gap_cycles) begin
          if (enable) begin
            state_d         = S_START;
            start_sending_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame finished (normally or by timeout): step indices, start the gap.
    if (advance) begin
      segment_num_d = adv_seg;
      txid_inter_d  = adv_txid;
      aux_d         = adv_aux;
      if (adv_wrap) seg_max_d = seg_max_sw;
      gap_cnt_d     = '0;
      state_d       = S_GAP;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk125MHz or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      seg_max       <= '0;
      ack_cnt       <= '0;
      gap_cnt       <= '0;
      segment_num   <= '0;
      txid_inter    <= 8'd0;
      aux           <= '0;
      start_sending <= 1'b0;
      timeout_cnt   <= 8'd0;
    end else begin
      state         <= state_d;
      seg_max       <= seg_max_d;
      ack_cnt       <= ack_cnt_d;
      gap_cnt       <= gap_cnt_d;
      segment_num   <= segment_num_d;
      txid_inter    <= txid_inter_d;
      aux           <= aux_d;
      start_sending <= start_sending_d;
      timeout_cnt   <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_send_control_mc.sv
// Bench for send_control_mc: frame-level reference model, scenario table,
// directed pause/reset/switch sequences and randomized frames.
module tb_send_control_mc;

  localparam int NTX = 3;

  logic        clk125MHz = 1'b0;
  logic        RST = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  switches = 8'd0;
  logic [15:0] gap_cycles = 16'd0;
  logic        busy = 1'b0;
  logic [15:0] segment_num;
  logic [7:0]  txid_inter;
  logic [7:0]  aux;
  logic        start_sending;
  logic [7:0]  timeout_cnt;

  send_control_mc dut (
    .clk125MHz    (clk125MHz),
    .RST          (RST),
    .enable       (enable),
    .mode         (mode),
    .switches     (switches),
    .gap_cycles   (gap_cycles),
    .busy         (busy),
    .segment_num  (segment_num),
    .txid_inter   (txid_inter),
    .aux          (aux),
    .start_sending(start_sending),
    .timeout_cnt  (timeout_cnt)
  );

  initial forever #4 clk125MHz = ~clk125MHz;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame builder model: busy rises lat+1 cycles after the START cycle and
  // stays high for len cycles; lat >= 200 means it never answers.
  int nxt_lat = 3, nxt_len = 10;
  int cur_lat = 3, cur_len = 10;
  int dly = 0, hi = 0, blen = 0;

  always @(negedge clk125MHz) begin
    if (!RST) begin
      busy = 1'b0; dly = 0; hi = 0;
    end else if (start_sending) begin
      if (nxt_lat < 200) begin dly = nxt_lat + 1; blen = nxt_len; end
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin busy = 1'b1; hi = blen; end
    end else if (hi > 0) begin
      hi--;
      if (hi == 0) busy = 1'b0;
    end
  end

  // Reference model: the (segment, copy) pair the next frame must carry.
  int m_seg, m_txid, m_aux, m_segmax, m_to;
  int max_seg_seen = 0;

  function automatic int segmax_of(input int sw);
    return (((sw + 1) << 4) - 1) & 32'hFFFF;
  endfunction

  function automatic int frame_period(input int lat, input int len, input int gap);
    if (lat >= 200) return 1 + 64 + 1 + gap;
    return 1 + (lat + 1) + len + 1 + gap;
  endfunction

  task automatic model_reset();
    m_seg = 0; m_txid = 0; m_aux = 0; m_to = 0;
    m_segmax = segmax_of(int'(switches));
  endtask

  task automatic model_adv(input bit md);
    bit wrap = 1'b0;
    if (!md) begin
      if (m_txid == NTX - 1) begin
        m_txid = 0;
        if (m_seg == m_segmax) begin m_seg = 0; wrap = 1'b1; end
        else m_seg++;
      end else m_txid++;
    end else begin
      if (m_seg == m_segmax) begin
        m_seg = 0;
        if (m_txid == NTX - 1) begin m_txid = 0; wrap = 1'b1; end
        else m_txid++;
      end else m_seg++;
    end
    if (wrap) begin
      m_aux = (m_aux + 1) % 256;
      m_segmax = segmax_of(int'(switches));
    end
  endtask

  task automatic wait_start(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk125MHz);
      cyc++;
      if (start_sending === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check("start_wait_expired", 0, 1);
  endtask

  task automatic wait_busy();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk125MHz);
      if (busy) seen = 1'b1;
    end
    if (!seen) check("busy_wait_expired", 0, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_seg"},  int'(segment_num), m_seg);
    check({tag, "_txid"}, int'(txid_inter),  m_txid);
    check({tag, "_aux"},  int'(aux),         m_aux);
    check({tag, "_tocnt"}, int'(timeout_cnt), m_to);
    if (int'(segment_num) > max_seg_seen) max_seg_seen = int'(segment_num);
  endtask

  task automatic do_reset(input bit md, input int sw, input int gap,
                          input int lat, input int len);
    @(negedge clk125MHz);
    RST = 1'b0; enable = 1'b0;
    mode = md; switches = 8'(sw); gap_cycles = 16'(gap);
    nxt_lat = lat; nxt_len = len; cur_lat = lat; cur_len = len;
    repeat (2) @(negedge clk125MHz);
    model_reset();
    max_seg_seen = 0;
    enable = 1'b1;
    RST = 1'b1;
  endtask

  // Run n frames, checking each start against the model and the period
  // against the frame-timing rule; exp_first checks release-to-start latency.
  task automatic run_frames(input int n, input bit rnd, input int exp_first,
                            input string tag);
    bit ok; int cyc; int exp_p = 0; int lat_k, len_k;
    for (int i = 0; i < n; i++) begin
      wait_start(ok, cyc);
      if (!ok) return;
      check_frame(tag);
      if (i == 0 && exp_first > 0) check({tag, "_first_latency"}, cyc, exp_first);
      if (exp_p > 0) check({tag, "_period"}, cyc, exp_p);
      #1;
      if (rnd) begin
        mode = 1'($urandom_range(0, 1));
        gap_cycles = 16'($urandom_range(0, 6));
      end
      lat_k = cur_lat; len_k = cur_len;
      if (rnd) begin
        nxt_lat = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 5));
        nxt_len = int'($urandom_range(1, 6));
      end
      cur_lat = nxt_lat; cur_len = nxt_len;
      exp_p = frame_period(lat_k, len_k, int'(gap_cycles));
      if (lat_k >= 200 && m_to < 255) m_to++;
      model_adv(mode);
    end
  endtask

  typedef struct {
    bit md; int sw; int gap; int lat; int len; int n;
    int seg; int txid; int ax; int to; int period;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok; int cyc; int cnt;

    vecs[0] = '{1'b0, 0, 5,   3, 10,  4,  1, 0, 0, 0, 21};
    vecs[1] = '{1'b0, 0, 5,   3, 10, 48, 15, 2, 0, 0, 21};
    vecs[2] = '{1'b0, 0, 5,   3, 10, 49,  0, 0, 1, 0, 21};
    vecs[3] = '{1'b1, 0, 5,   3, 10, 16, 15, 0, 0, 0, 21};
    vecs[4] = '{1'b1, 0, 5,   3, 10, 17,  0, 1, 0, 0, 21};
    vecs[5] = '{1'b1, 0, 5,   3, 10, 49,  0, 0, 1, 0, 21};
    vecs[6] = '{1'b0, 0, 0,   0,  1,  2,  0, 1, 0, 0,  4};
    vecs[7] = '{1'b1, 1, 2,   1,  2, 33,  0, 1, 0, 0,  8};
    vecs[8] = '{1'b0, 0, 0, 255,  1,  3,  0, 2, 0, 2, 66};

    // Reset values while RST is held low.
    repeat (2) @(negedge clk125MHz);
    check("rst_seg", int'(segment_num), 0);
    check("rst_txid", int'(txid_inter), 0);
    check("rst_aux", int'(aux), 0);
    check("rst_start", int'(start_sending), 0);
    check("rst_tocnt", int'(timeout_cnt), 0);

    // Scenario table: hand-derived indices and period at frame n.
    foreach (vecs[k]) begin
      do_reset(vecs[k].md, vecs[k].sw, vecs[k].gap, vecs[k].lat, vecs[k].len);
      run_frames(vecs[k].n - 1, 1'b0, 0, $sformatf("vec%0d_pre", k));
      wait_start(ok, cyc);
      if (ok) begin
        check($sformatf("vec%0d_seg", k),    int'(segment_num), vecs[k].seg);
        check($sformatf("vec%0d_txid", k),   int'(txid_inter),  vecs[k].txid);
        check($sformatf("vec%0d_aux", k),    int'(aux),         vecs[k].ax);
        check($sformatf("vec%0d_tocnt", k),  int'(timeout_cnt), vecs[k].to);
        check($sformatf("vec%0d_period", k), cyc,               vecs[k].period);
      end
    end

    // No acknowledge ever: 66-cycle period, timeout counter saturates.
    // IDLE lasts one cycle after release, START is the second cycle.
    do_reset(1'b0, 8'h5F, 0, 255, 1);
    run_frames(258, 1'b0, 1, "noack");
    check("noack_tocnt_sat", int'(timeout_cnt), 255);

    // Pause: drop enable while the builder is busy; resume without skip.
    do_reset(1'b0, 0, 2, 3, 10);
    run_frames(5, 1'b0, 0, "pause_pre");
    wait_busy();
    repeat (2) @(negedge clk125MHz);
    enable = 1'b0;
    cnt = 0;
    repeat (150) begin
      @(negedge clk125MHz);
      if (start_sending) cnt++;
    end
    check("pause_no_start", cnt, 0);
    enable = 1'b1;
    run_frames(4, 1'b0, 0, "pause_resume");

    // Asynchronous reset in the middle of a frame carrying segment 7.
    do_reset(1'b0, 0, 0, 3, 10);
    run_frames(21, 1'b0, 0, "rst_pre");
    wait_start(ok, cyc);
    check("rst_mid_seg_before", int'(segment_num), 7);
    wait_busy();
    repeat (2) @(negedge clk125MHz);
    #1 RST = 1'b0;
    #1;
    check("rst_mid_seg", int'(segment_num), 0);
    check("rst_mid_txid", int'(txid_inter), 0);
    check("rst_mid_aux", int'(aux), 0);
    check("rst_mid_start", int'(start_sending), 0);
    check("rst_mid_tocnt", int'(timeout_cnt), 0);
    do_reset(1'b0, 0, 0, 3, 10);
    run_frames(3, 1'b0, 0, "rst_post");

    // Switches change mid-pass: limit 15 holds until wrap, then 31.
    do_reset(1'b0, 0, 0, 0, 1);
    run_frames(10, 1'b0, 0, "sw_a");
    switches = 8'd1;
    run_frames(39, 1'b0, 0, "sw_b");
    check("sw_pass1_max", max_seg_seen, 15);
    run_frames(96, 1'b0, 0, "sw_c");
    check("sw_pass2_max", max_seg_seen, 31);

    // Randomized gaps, latencies, busy lengths, timeouts and mode flips.
    do_reset(1'b0, 0, 3, 2, 3);
    run_frames(300, 1'b1, 0, "rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
